// File: rtl/snn_neuron_pkg.sv
// Shared types and constants for the spiking-neuron array: op codes and membrane saturation limits.
package snn_neuron_pkg;

    typedef enum logic [1:0] {
        OP_ACC   = 2'd0,
        OP_STEP  = 2'd1,
        OP_CLEAR = 2'd2,
        OP_NOP   = 2'd3
    } op_code_e;

    function automatic longint mem_sat_max(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    function automatic longint mem_sat_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/lif_neuron_alu.sv
// Combinational neuron datapath: saturating accumulate, threshold compare, leak and ReLU.
// Leak is applied only when LIF_NEURON_LEAK_EN is defined; otherwise the neuron is pure integrate-and-fire.
module lif_neuron_alu
    import snn_neuron_pkg::*;
#(
    parameter int MEM_WIDTH    = 12,
    parameter int WEIGHT_WIDTH = 8,
    parameter int LEAK_SHIFT   = 3
) (
    input  logic signed [MEM_WIDTH-1:0]    mem,
    input  logic signed [WEIGHT_WIDTH-1:0] weight,
    input  logic signed [MEM_WIDTH-1:0]    thr,
    output logic signed [MEM_WIDTH-1:0]    acc_mem,
    output logic                           fire,
    output logic signed [MEM_WIDTH-1:0]    decay_mem
);

    localparam logic signed [MEM_WIDTH:0] SAT_MAX = (MEM_WIDTH + 1)'(mem_sat_max(MEM_WIDTH));
    localparam logic signed [MEM_WIDTH:0] SAT_MIN = (MEM_WIDTH + 1)'(mem_sat_min(MEM_WIDTH));

    logic signed [MEM_WIDTH:0]   sum;
    logic signed [MEM_WIDTH-1:0] leaked;

    // One extra bit of headroom lets the overflow be detected before clamping.
    assign sum = {mem[MEM_WIDTH-1], mem}
               + {{(MEM_WIDTH - WEIGHT_WIDTH + 1){weight[WEIGHT_WIDTH-1]}}, weight};

    always_comb begin
        if (sum > SAT_MAX) begin
            acc_mem = SAT_MAX[MEM_WIDTH-1:0];
        end else if (sum < SAT_MIN) begin
            acc_mem = SAT_MIN[MEM_WIDTH-1:0];
        end else begin
            acc_mem = sum[MEM_WIDTH-1:0];
        end
    end

    assign fire = (mem >= thr);

`ifdef LIF_NEURON_LEAK_EN
    assign leaked = mem - (mem >>> LEAK_SHIFT);
`else
    assign leaked = mem;
`endif

    assign decay_mem = leaked[MEM_WIDTH-1] ? '0 : leaked;

endmodule

// File: rtl/lif_neuron_array.sv
// Array of N_NEUR leaky integrate-and-fire neurons with a 2-stage read/compute pipeline and forwarding.
// Optional leak on non-firing STEP is enabled by defining LIF_NEURON_LEAK_EN.
module lif_neuron_array
    import snn_neuron_pkg::*;
#(
    parameter int N_NEUR       = 16,
    parameter int MEM_WIDTH    = 12,
    parameter int WEIGHT_WIDTH = 8,
    parameter int TIME_STEP    = 8,
    parameter int LEAK_SHIFT   = 3
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          op_valid,
    output logic                          op_ready,
    input  logic [1:0]                    op_code,
    input  logic [$clog2(N_NEUR)-1:0]     op_addr,
    input  logic signed [WEIGHT_WIDTH-1:0] op_weight,
    input  logic [$clog2(TIME_STEP)-1:0]  op_tstep,
    input  logic signed [MEM_WIDTH-1:0]   param_thr,
    output logic                          spike_valid,
    output logic [$clog2(N_NEUR)-1:0]     spike_addr,
    output logic [$clog2(TIME_STEP)-1:0]  spike_tstep,
    input  logic [$clog2(N_NEUR)-1:0]     rd_addr,
    output logic [TIME_STEP-1:0]          rd_bitmap,
    output logic signed [MEM_WIDTH-1:0]   rd_mem
);

    localparam int AW = $clog2(N_NEUR);
    localparam int TW = $clog2(TIME_STEP);

    typedef struct packed {
        op_code_e                      code;
        logic [AW-1:0]                 addr;
        logic signed [WEIGHT_WIDTH-1:0] weight;
        logic [TW-1:0]                 tstep;
    } op_t;

    logic signed [MEM_WIDTH-1:0] mem_q [N_NEUR];
    logic [TIME_STEP-1:0]        bmp_q [N_NEUR];

    logic                        ready_q;
    logic                        accept;
    logic                        s1_valid, s2_valid;
    op_t                         s1_op, s2_op;
    logic signed [MEM_WIDTH-1:0] s2_mem;
    logic [TIME_STEP-1:0]        s2_bmp;

    logic signed [MEM_WIDTH-1:0] acc_mem, decay_mem;
    logic                        fire;
    logic                        wb_en;
    logic signed [MEM_WIDTH-1:0] wb_mem;
    logic [TIME_STEP-1:0]        wb_bmp;
    logic                        spike_fire;
    logic                        fwd;

    assign op_ready = ready_q;
    assign accept   = op_valid && ready_q;

    lif_neuron_alu #(
        .MEM_WIDTH   (MEM_WIDTH),
        .WEIGHT_WIDTH(WEIGHT_WIDTH),
        .LEAK_SHIFT  (LEAK_SHIFT)
    ) u_alu (
        .mem      (s2_mem),
        .weight   (s2_op.weight),
        .thr      (param_thr),
        .acc_mem  (acc_mem),
        .fire     (fire),
        .decay_mem(decay_mem)
    );

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        wb_en      = 1'b0;
        wb_mem     = s2_mem;
        wb_bmp     = s2_bmp;
        spike_fire = 1'b0;
        if (s2_valid) begin
            case (s2_op.code)
                OP_ACC: begin
                    wb_en  = 1'b1;
                    wb_mem = acc_mem;
                end
                OP_STEP: begin
                    wb_en = 1'b1;
                    if (fire) begin
                        spike_fire = 1'b1;
                        wb_mem     = '0;
                        if (int'(s2_op.tstep) < TIME_STEP) begin
                            wb_bmp[s2_op.tstep] = 1'b1;
                        end
                    end else begin
                        wb_mem = decay_mem;
                    end
                end
                OP_CLEAR: begin
                    wb_en  = 1'b1;
                    wb_mem = '0;
                    wb_bmp = '0;
                end
                default: ;
            endcase
        end
    end

    // The op reading in stage 1 sees the array before this cycle's write-back lands, so take it from stage 2.
    assign fwd = s2_valid && wb_en && (s2_op.addr == s1_op.addr);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ready_q     <= 1'b0;
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            spike_valid <= 1'b0;
            spike_addr  <= '0;
            spike_tstep <= '0;
            rd_mem      <= '0;
            rd_bitmap   <= '0;
            // NOTE: the neuron state is a flop array rather than a RAM macro, so clearing every entry in the reset cycle is legitimate.
            for (int i = 0; i < N_NEUR; i++) begin
                mem_q[i] <= '0;
                bmp_q[i] <= '0;
            end
        end else begin
            ready_q     <= 1'b1;
            s1_valid    <= accept;
            s2_valid    <= s1_valid;
            spike_valid <= spike_fire;
            if (spike_fire) begin
                spike_addr  <= s2_op.addr;
                spike_tstep <= s2_op.tstep;
            end
            if (wb_en) begin
                mem_q[s2_op.addr] <= wb_mem;
                bmp_q[s2_op.addr] <= wb_bmp;
            end
            rd_mem    <= mem_q[rd_addr];
            rd_bitmap <= bmp_q[rd_addr];
        end
    end

    // Pipeline payload needs no reset: it is qualified everywhere by the valid bits.
    always_ff @(posedge CLK) begin
        if (accept) begin
            s1_op.code   <= op_code_e'(op_code);
            s1_op.addr   <= op_addr;
            s1_op.weight <= op_weight;
            s1_op.tstep  <= op_tstep;
        end
        s2_op  <= s1_op;
        s2_mem <= fwd ? wb_mem : mem_q[s1_op.addr];
        s2_bmp <= fwd ? wb_bmp : bmp_q[s1_op.addr];
    end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Scoreboard bench for lif_neuron_array: directed ops push expected spikes/reads, monitors pop and compare.
// Expected leak results follow LIF_NEURON_LEAK_EN in the same way as the design.
`timescale 1ns/1ps
module tb_lif_neuron_array;
    import snn_neuron_pkg::*;

    localparam int N_NEUR       = 16;
    localparam int MEM_WIDTH    = 12;
    localparam int WEIGHT_WIDTH = 8;
    localparam int TIME_STEP    = 8;
    localparam int LEAK_SHIFT   = 3;
    localparam int AW           = 4;
    localparam int TW           = 3;

`ifdef LIF_NEURON_LEAK_EN
    localparam int EXP_MEM80  = 70;
    localparam int EXP_MEM199 = 175;
`else
    localparam int EXP_MEM80  = 80;
    localparam int EXP_MEM199 = 199;
`endif

    logic                           CLK = 1'b0;
    logic                           RST = 1'b1;
    logic                           op_valid = 1'b0;
    logic                           op_ready;
    logic [1:0]                     op_code = 2'd3;
    logic [AW-1:0]                  op_addr = '0;
    logic signed [WEIGHT_WIDTH-1:0] op_weight = '0;
    logic [TW-1:0]                  op_tstep = '0;
    logic signed [MEM_WIDTH-1:0]    param_thr = '0;
    logic                           spike_valid;
    logic [AW-1:0]                  spike_addr;
    logic [TW-1:0]                  spike_tstep;
    logic [AW-1:0]                  rd_addr = '0;
    logic [TIME_STEP-1:0]           rd_bitmap;
    logic signed [MEM_WIDTH-1:0]    rd_mem;

    lif_neuron_array #(
        .N_NEUR      (N_NEUR),
        .MEM_WIDTH   (MEM_WIDTH),
        .WEIGHT_WIDTH(WEIGHT_WIDTH),
        .TIME_STEP   (TIME_STEP),
        .LEAK_SHIFT  (LEAK_SHIFT)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .op_addr    (op_addr),
        .op_weight  (op_weight),
        .op_tstep   (op_tstep),
        .param_thr  (param_thr),
        .spike_valid(spike_valid),
        .spike_addr (spike_addr),
        .spike_tstep(spike_tstep),
        .rd_addr    (rd_addr),
        .rd_bitmap  (rd_bitmap),
        .rd_mem     (rd_mem)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int addr;
        int tstep;
        int cyc;
    } spike_t;

    typedef struct {
        int addr;
        int mem;
        int bmp;
    } rd_t;

    spike_t spike_q[$];
    rd_t    rd_q[$];
    int     n_vec  = 0;
    int     n_fail = 0;
    int     cyc    = 0;
    logic   rd_req = 1'b0;
    logic   rd_chk = 1'b0;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge CLK) begin
        cyc    <= cyc + 1;
        rd_chk <= rd_req;
    end

    // Monitors: compare whatever the DUT presents against the head of each queue.
    always @(negedge CLK) begin
        spike_t s;
        rd_t    r;
        if (spike_valid) begin
            if (spike_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_spike: got addr %0d tstep %0d at cycle %0d, expected none",
                         spike_addr, spike_tstep, cyc);
            end else begin
                s = spike_q.pop_front();
                check("spike_addr", spike_addr, s.addr);
                check("spike_tstep", spike_tstep, s.tstep);
                check("spike_cycle", cyc, s.cyc);
            end
        end
        if (rd_chk) begin
            if (rd_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL read_underflow: got a read strobe, expected none");
            end else begin
                r = rd_q.pop_front();
                check($sformatf("rd_mem[%0d]", r.addr), rd_mem, r.mem);
                check($sformatf("rd_bitmap[%0d]", r.addr), rd_bitmap, r.bmp);
            end
        end
    end

    task automatic issue(input op_code_e op, input int addr, input int w, input int ts, input bit exp_spike);
        @(negedge CLK);
        op_valid  = 1'b1;
        op_code   = op;
        op_addr   = AW'(addr);
        op_weight = WEIGHT_WIDTH'(w);
        op_tstep  = TW'(ts);
        rd_req    = 1'b0;
        // Accepted at the next edge; spike registered two edges after that.
        if (exp_spike) spike_q.push_back('{addr, ts, cyc + 3});
    endtask

    task automatic idle(input int n);
        @(negedge CLK);
        op_valid = 1'b0;
        rd_req   = 1'b0;
        repeat (n - 1) @(negedge CLK);
    endtask

    task automatic do_read(input int addr, input int mem, input int bmp);
        @(negedge CLK);
        op_valid = 1'b0;
        rd_addr  = AW'(addr);
        rd_req   = 1'b1;
        rd_q.push_back('{addr, mem, bmp});
    endtask

    task automatic do_reset(input int n);
        @(negedge CLK);
        RST      = 1'b1;
        op_valid = 1'b0;
        rd_req   = 1'b0;
        repeat (n) @(negedge CLK);
        check("op_ready_in_rst", op_ready, 0);
        check("spike_valid_rst", spike_valid, 0);
        check("spike_addr_rst", spike_addr, 0);
        check("spike_tstep_rst", spike_tstep, 0);
        check("rd_mem_rst", rd_mem, 0);
        check("rd_bitmap_rst", rd_bitmap, 0);
        RST = 1'b0;
        @(negedge CLK);
        check("op_ready_after_rst", op_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(3);
        do_read(0, 0, 0);
        do_read(15, 0, 0);

        // Two accumulates then a firing STEP, all back to back on one address.
        param_thr = 12'sd150;
        issue(OP_ACC, 3, 100, 0, 0);
        issue(OP_ACC, 3, 100, 0, 0);
        issue(OP_STEP, 3, 0, 2, 1);
        idle(3);
        do_read(3, 0, 8'h04);

        // Forwarded spike must zero the membrane seen by the following STEP.
        param_thr = 12'sd100;
        issue(OP_ACC, 5, 60, 0, 0);
        issue(OP_ACC, 5, 60, 0, 0);
        issue(OP_STEP, 5, 0, 1, 1);
        issue(OP_STEP, 5, 0, 2, 0);
        idle(3);
        do_read(5, 0, 8'h02);

        // Saturation at both rails.
        for (int i = 0; i < 16; i++) issue(OP_ACC, 1, 127, 0, 0);
        issue(OP_ACC, 1, 8, 0, 0);
        for (int i = 0; i < 16; i++) issue(OP_ACC, 2, -127, 0, 0);
        issue(OP_ACC, 2, -8, 0, 0);
        idle(3);
        do_read(1, 2040, 0);
        do_read(2, -2040, 0);
        issue(OP_ACC, 1, 100, 0, 0);
        issue(OP_ACC, 2, -100, 0, 0);
        idle(3);
        do_read(1, 2047, 0);
        do_read(2, -2048, 0);
        issue(OP_STEP, 1, 0, 7, 1);
        issue(OP_STEP, 2, 0, 6, 0);
        idle(3);
        do_read(1, 0, 8'h80);
        do_read(2, 0, 0);

        // Leak / ReLU and threshold equality.
        param_thr = 12'sd200;
        issue(OP_ACC, 4, 80, 0, 0);
        issue(OP_ACC, 8, -20, 0, 0);
        issue(OP_ACC, 9, 100, 0, 0);
        issue(OP_ACC, 9, 100, 0, 0);
        issue(OP_ACC, 10, 100, 0, 0);
        issue(OP_ACC, 10, 99, 0, 0);
        idle(3);
        issue(OP_STEP, 4, 0, 0, 0);
        issue(OP_STEP, 8, 0, 0, 0);
        issue(OP_STEP, 9, 0, 3, 1);
        issue(OP_STEP, 10, 0, 3, 0);
        issue(OP_NOP, 4, 50, 1, 0);
        idle(3);
        do_read(4, EXP_MEM80, 0);
        do_read(8, 0, 0);
        do_read(9, 0, 8'h08);
        do_read(10, EXP_MEM199, 0);

        // Two spikes on one neuron, then CLEAR it and confirm neighbours survive.
        param_thr = 12'sd100;
        issue(OP_ACC, 7, 100, 0, 0);
        issue(OP_STEP, 7, 0, 0, 1);
        issue(OP_ACC, 7, 127, 0, 0);
        issue(OP_STEP, 7, 0, 5, 1);
        issue(OP_ACC, 7, 30, 0, 0);
        idle(3);
        do_read(7, 30, 8'h21);
        issue(OP_CLEAR, 7, 0, 0, 0);
        idle(3);
        do_read(7, 0, 0);
        do_read(4, EXP_MEM80, 0);
        do_read(3, 0, 8'h04);
        do_read(9, 0, 8'h08);

        // Reset one cycle after a firing STEP is accepted: the spike must be dropped.
        issue(OP_ACC, 11, 120, 0, 0);
        idle(3);
        issue(OP_STEP, 11, 0, 4, 0);
        do_reset(2);
        do_read(11, 0, 0);
        do_read(3, 0, 0);
        do_read(7, 0, 0);
        do_read(9, 0, 0);
        issue(OP_ACC, 0, 5, 0, 0);
        idle(3);
        do_read(0, 5, 0);
        idle(4);

        check("spike_queue_drained", spike_q.size(), 0);
        check("read_queue_drained", rd_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
